// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu register-side master: register map,
// status bit layout, state encodings and a popcount helper.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam int STAT_READY_BIT = 1;
  localparam int STAT_VALID_BIT = 0;
  localparam logic [1:0]  STAT_DONE  = 2'b11;
  localparam logic [31:0] START_WORD = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_A1    = 3'd1,
    ST_WR_A2    = 3'd2,
    ST_WR_START = 3'd3,
    ST_POLL     = 3'd4,
    ST_RD_W     = 3'd5,
    ST_RD_L     = 3'd6,
    ST_RESP     = 3'd7
  } master_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } bus_phase_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// One peripheral register access: SETUP (1) -> STROBE (STROBE_CYCLES) -> HOLD (1).
// A new go may be taken in HOLD so back-to-back accesses have no idle gap.
module gpioemu_bus_cycle
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  phase_dbg,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  bus_phase_e  phase_q;
  logic [CW-1:0] cnt_q;
  logic        rd_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic        swr_q;
  logic        srd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      swr_q   <= 1'b0;
      srd_q   <= 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE, PH_HOLD: begin
          if (go) begin
            phase_q <= PH_SETUP;
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_q    <= rd;
          end else begin
            phase_q <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          phase_q <= PH_STROBE;
          cnt_q   <= '0;
          swr_q   <= ~rd_q;
          srd_q   <= rd_q;
        end
        PH_STROBE: begin
          if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
            phase_q <= PH_HOLD;
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  // rdata is only meaningful while done is high; the caller samples it on that edge.
  assign done      = (phase_q == PH_HOLD);
  assign rdata     = sdata_in;
  assign phase_dbg = phase_q;
  assign saddress  = addr_q;
  assign swr       = swr_q;
  assign srd       = srd_q;
  assign sdata_out = wdata_q;

endmodule

// File: rtl/gpioemu_master.sv
// Register-side master for the gpioemu multiplier: write operands, start,
// poll status, read W and L, return a response. Optional GPIOEMU_MASTER_POPCOUNT_CHECK_EN.
module gpioemu_master
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic [1:0]  rsp_status,
  output logic        rsp_timeout,
  output logic        rsp_err,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic [2:0]  dbg_state,
  output logic [1:0]  dbg_bus_phase
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // the response stays valid with stable fields until that edge.
  localparam int PCW = $clog2(POLL_LIMIT + 1);

  master_state_e st_q, st_d;
  logic          cmd_ready_q;
  logic [23:0]   a2_q;
  logic [PCW-1:0] poll_cnt_q;
  logic [31:0]   rsp_w_q;
  logic [23:0]   rsp_l_q;
  logic [1:0]    rsp_status_q;
  logic          rsp_timeout_q;
  logic          rsp_valid_q;

  logic          accept;
  logic          timeout_hit;
  logic          bus_go, bus_rd, bus_done;
  logic [15:0]   bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;
  logic [1:0]    status;

  assign accept = (st_q == ST_IDLE) && cmd_ready_q && cmd_valid;
  assign status = {bus_rdata[STAT_READY_BIT], bus_rdata[STAT_VALID_BIT]};

  // The next access is launched on the same edge the current one finishes.
  always_comb begin
    st_d        = st_q;
    timeout_hit = 1'b0;
    case (st_q)
      ST_IDLE:     if (accept)   st_d = ST_WR_A1;
      ST_WR_A1:    if (bus_done) st_d = ST_WR_A2;
      ST_WR_A2:    if (bus_done) st_d = ST_WR_START;
      ST_WR_START: if (bus_done) st_d = ST_POLL;
      ST_POLL: begin
        if (bus_done) begin
          if (status == STAT_DONE) begin
            st_d = ST_RD_W;
          end else if (poll_cnt_q == PCW'(POLL_LIMIT - 1)) begin
            st_d        = ST_RESP;
            timeout_hit = 1'b1;
          end
        end
      end
      ST_RD_W:     if (bus_done) st_d = ST_RD_L;
      ST_RD_L:     if (bus_done) st_d = ST_RESP;
      ST_RESP:     if (rsp_ready) st_d = ST_IDLE;
      default:     st_d = ST_IDLE;
    endcase

    bus_go = accept || (bus_done && (st_d inside {ST_WR_A2, ST_WR_START, ST_POLL,
                                                  ST_RD_W, ST_RD_L}));
    bus_rd    = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 32'h0;
    case (st_d)
      ST_WR_A1:    begin bus_addr = ADDR_A1;   bus_wdata = {8'h00, cmd_a1}; end
      ST_WR_A2:    begin bus_addr = ADDR_A2;   bus_wdata = {8'h00, a2_q};   end
      ST_WR_START: begin bus_addr = ADDR_CTRL; bus_wdata = START_WORD;      end
      ST_POLL:     begin bus_addr = ADDR_CTRL; bus_rd = 1'b1; end
      ST_RD_W:     begin bus_addr = ADDR_W;    bus_rd = 1'b1; end
      ST_RD_L:     begin bus_addr = ADDR_L;    bus_rd = 1'b1; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      a2_q          <= '0;
      poll_cnt_q    <= '0;
      rsp_w_q       <= '0;
      rsp_l_q       <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      cmd_ready_q <= (st_d == ST_IDLE);
      if (accept) begin
        a2_q          <= cmd_a2;
        poll_cnt_q    <= '0;
        rsp_w_q       <= '0;
        rsp_l_q       <= '0;
        rsp_status_q  <= '0;
        rsp_timeout_q <= 1'b0;
      end
      if (st_q == ST_POLL && bus_done) begin
        poll_cnt_q   <= poll_cnt_q + PCW'(1);
        rsp_status_q <= status;
        if (timeout_hit) rsp_timeout_q <= 1'b1;
      end
      if (st_q == ST_RD_W && bus_done) rsp_w_q <= bus_rdata;
      if (st_q == ST_RD_L && bus_done) rsp_l_q <= bus_rdata[23:0];
      if (st_d == ST_RESP && st_q != ST_RESP) rsp_valid_q <= 1'b1;
      else if (st_q == ST_RESP && rsp_ready)  rsp_valid_q <= 1'b0;
    end
  end

`ifdef GPIOEMU_MASTER_POPCOUNT_CHECK_EN
  logic rsp_err_q;
  // W is already captured when L arrives; a timed-out transaction never reaches RD_L.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      rsp_err_q <= 1'b0;
    end else if (st_q == ST_RD_L && bus_done) begin
      rsp_err_q <= ({18'b0, popcount32(rsp_w_q)} != bus_rdata[23:0]);
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  gpioemu_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk       (clk),
    .reset     (reset),
    .go        (bus_go),
    .rd        (bus_rd),
    .addr      (bus_addr),
    .wdata     (bus_wdata),
    .done      (bus_done),
    .rdata     (bus_rdata),
    .phase_dbg (dbg_bus_phase),
    .saddress  (saddress),
    .swr       (swr),
    .srd       (srd),
    .sdata_out (sdata_out),
    .sdata_in  (sdata_in)
  );

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_w       = rsp_w_q;
  assign rsp_l       = rsp_l_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state   = st_q;

endmodule

// File: tb/tb_gpioemu_master.sv
// Directed bench for gpioemu_master with a behavioural peripheral responder.
module tb_gpioemu_master;

  localparam int SC  = 2;
  localparam int PL  = 4;
  localparam int ACC = SC + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_a1 = '0;
  logic [23:0] cmd_a2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_w;
  logic [23:0] rsp_l;
  logic [1:0]  rsp_status;
  logic        rsp_timeout;
  logic        rsp_err;
  logic [15:0] saddress;
  logic        swr, srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_bus_phase;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gpioemu_master #(.STROBE_CYCLES(SC), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_w(rsp_w), .rsp_l(rsp_l), .rsp_status(rsp_status),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .saddress(saddress), .swr(swr), .srd(srd),
    .sdata_out(sdata_out), .sdata_in(sdata_in),
    .dbg_state(dbg_state), .dbg_bus_phase(dbg_bus_phase)
  );

  // ---------------- peripheral responder ----------------
  int          stat_reads = 0;
  int          busy_n = 0;
  logic [1:0]  stuck = 2'b01;
  logic [31:0] w_val = '0;
  logic [31:0] l_val = '0;

  always_comb begin
    sdata_in = 32'hBAD0_0000;
    case (saddress)
      16'h03A0: sdata_in = {30'b0, (stat_reads <= busy_n) ? stuck : 2'b11};
      16'h0390: sdata_in = w_val;
      16'h0398: sdata_in = l_val;
      default:  ;
    endcase
  end

  // ---------------- bus monitor / scoreboard ----------------
  logic [48:0] exp_q[$];
  logic [48:0] obs_q[$];
  logic swr_prev = 1'b0, srd_prev = 1'b0;
  int   run_len = 0, len_err = 0, excl_err = 0;

  always @(posedge clk) begin
    if (swr && !swr_prev) obs_q.push_back({1'b0, saddress, sdata_out});
    if (srd && !srd_prev) begin
      obs_q.push_back({1'b1, saddress, 32'h0});
      if (saddress == 16'h03A0) stat_reads = stat_reads + 1;
    end
    if (swr && srd) excl_err = excl_err + 1;
    if (swr || srd) run_len = run_len + 1;
    else if (run_len != 0) begin
      if (run_len != SC) len_err = len_err + 1;
      run_len = 0;
    end
    swr_prev = swr;
    srd_prev = srd;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [23:0] a1, input logic [23:0] a2, output int lat);
    for (int k = 0; k < 50 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    cmd_a1 = a1;
    cmd_a2 = a2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask

  task automatic setup_responder(input int busy, input logic [1:0] st,
                                 input logic [31:0] w, input logic [31:0] l);
    busy_n = busy;
    stuck = st;
    w_val = w;
    l_val = l;
    stat_reads = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [23:0] a1, a2;
    int          busy;
    logic [1:0]  stuck;
    logic [31:0] w, l;
    logic [31:0] exp_w;
    logic [23:0] exp_l;
    logic [1:0]  exp_status;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int n_polls;
    logic exp_err;
    int bad;
    int found;

    vecs[0] = '{24'h000003, 24'h000005, 0,   2'b01, 32'h0000000F, 32'h00000004,
                32'h0000000F, 24'h000004, 2'b11, 1'b0, 24};
    vecs[1] = '{24'hFFFFFF, 24'h800001, 3,   2'b01, 32'h12345678, 32'hAB00000D,
                32'h12345678, 24'h00000D, 2'b11, 1'b0, 36};
    vecs[2] = '{24'h0000AA, 24'h000055, 100, 2'b01, 32'h0000DEAD, 32'h00000005,
                32'h00000000, 24'h000000, 2'b01, 1'b1, (3 + PL) * ACC};
    vecs[3] = '{24'h000011, 24'h00000F, 1,   2'b00, 32'h000000FF, 32'h00000007,
                32'h000000FF, 24'h000007, 2'b11, 1'b0, 28};
    vecs[4] = '{24'h123456, 24'h000002, 2,   2'b10, 32'h000000FF, 32'h00000008,
                32'h000000FF, 24'h000008, 2'b11, 1'b0, 32};

    // Reset held with a pending command: nothing may move on the bus.
    cmd_valid = 1'b1;
    cmd_a1 = 24'h000003;
    cmd_a2 = 24'h000005;
    repeat (4) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_bus", {saddress, swr, srd, sdata_out}, 50'h0);
    check("rst_rsp_fields", {rsp_w, rsp_l, rsp_status, rsp_timeout, rsp_err}, 60'h0);
    check("rst_state", dbg_state, 3'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    check("no_access_in_reset", obs_q.size(), 0);

    // Table-driven transactions.
    for (int i = 0; i < 5; i++) begin
      setup_responder(vecs[i].busy, vecs[i].stuck, vecs[i].w, vecs[i].l);
      n_polls = vecs[i].exp_to ? PL : vecs[i].busy + 1;
      exp_q.push_back({1'b0, 16'h0380, 8'h00, vecs[i].a1});
      exp_q.push_back({1'b0, 16'h0388, 8'h00, vecs[i].a2});
      exp_q.push_back({1'b0, 16'h03A0, 32'h1});
      for (int p = 0; p < n_polls; p++) exp_q.push_back({1'b1, 16'h03A0, 32'h0});
      if (!vecs[i].exp_to) begin
        exp_q.push_back({1'b1, 16'h0390, 32'h0});
        exp_q.push_back({1'b1, 16'h0398, 32'h0});
      end
`ifdef GPIOEMU_MASTER_POPCOUNT_CHECK_EN
      exp_err = !vecs[i].exp_to && ($countones(vecs[i].exp_w) != int'(vecs[i].exp_l));
`else
      exp_err = 1'b0;
`endif
      do_cmd(vecs[i].a1, vecs[i].a2, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rsp_w", i), rsp_w, vecs[i].exp_w);
      check($sformatf("v%0d_rsp_l", i), rsp_l, vecs[i].exp_l);
      check($sformatf("v%0d_rsp_status", i), rsp_status, vecs[i].exp_status);
      check($sformatf("v%0d_rsp_timeout", i), rsp_timeout, vecs[i].exp_to);
      check($sformatf("v%0d_rsp_err", i), rsp_err, exp_err);
      check($sformatf("v%0d_access_count", i), obs_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
        check($sformatf("v%0d_access%0d", i, k), obs_q[k], exp_q[k]);
      handshake();
    end

    // Back-pressured response: fields stable, no new command, bus quiet.
    setup_responder(0, 2'b01, 32'h00000F0F, 32'h00000008);
    do_cmd(24'h000101, 24'h000202, lat);
    check("stall_latency", lat, 24);
    found = obs_q.size();
    bad = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_w !== 32'h00000F0F || rsp_l !== 24'h000008 ||
          rsp_status !== 2'b11 || cmd_ready !== 1'b0 || swr || srd || dbg_state !== 3'd7)
        bad++;
    end
    cmd_valid = 1'b0;
    check("stall_stable_cycles_bad", bad, 0);
    check("stall_no_bus_activity", obs_q.size(), found);
    handshake();

    check("strobe_exclusive", excl_err, 0);
    check("strobe_length", len_err, 0);

    // Reset during the A2 write strobe discards the transaction.
    setup_responder(0, 2'b01, 32'h1, 32'h1);
    cmd_a1 = 24'h000007;
    cmd_a2 = 24'h000009;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (swr && saddress == 16'h0388) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reached_wr_a2_strobe", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_swr", swr, 1'b0);
    check("midrst_saddress", saddress, 16'h0000);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) bad++;
    end
    check("midrst_no_response", bad, 0);
    check("midrst_idle_ready", cmd_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
